axi_lite_write_arbiter: RTL and testbench
=========================================

Name: axi_lite_write_arbiter

Overview:
- Shares one AXI-Lite master write path (AW, W and B channels) between NUM_REQ local requesters.
- Each requester presents a single-beat write request. The block picks a winner round-robin, drives AW and W with independent handshakes, waits for B, and returns the response to the winner.
- Sits between internal register/DMA control clients and the system interconnect's AXI-Lite slave port.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
AXI_AWADDR_WIDTH, 8, address width
AXI_WDATA_WIDTH, 32, data width (32 or 64); strobe width is AXI_WDATA_WIDTH/8

Ports:
aclk  in  1  clock; all logic on rising edge
aresetn  in  1  reset, asynchronous and active-low
req  in  NUM_REQ  per-requester write request; held until done
req_addr  in  NUM_REQ*AXI_AWADDR_WIDTH  packed per-requester address, slice i = requester i
req_data  in  NUM_REQ*AXI_WDATA_WIDTH  packed per-requester write data
req_strb  in  NUM_REQ*AXI_WDATA_WIDTH/8  packed per-requester byte strobes
req_prot  in  NUM_REQ*3  packed per-requester awprot
done  out  NUM_REQ  one-cycle completion pulse, one-hot
resp  out  2  bresp of completed transaction, valid while done!=0
busy  out  1  high in any state other than IDLE
awvalid/awready/awaddr/awprot  out/in/out/out  1/1/AXI_AWADDR_WIDTH/3  AXI-Lite write address channel, master side
wvalid/wready/wdata/wstrb  out/in/out/out  1/1/AXI_WDATA_WIDTH/AXI_WDATA_WIDTH/8  write data channel, master side
bvalid/bready/bresp  in/out/in  1/1/2  write response channel, master side

Behaviour:
- Reset (asynchronous, aresetn=0): state=IDLE; awvalid, wvalid, bready, done, busy = 0; resp, awaddr, awprot, wdata, wstrb = 0; round-robin pointer = 0, so requester 0 has highest priority.
- Reset mid-transaction aborts immediately to the reset values. No done pulse is issued. Interconnect recovery is the system's concern.
- State machine: IDLE -> SEND -> RESP -> DONE -> IDLE. All outputs are registered.
- IDLE:
  - If req!=0, choose the first set bit scanning from ptr upward, modulo NUM_REQ.
  - Latch that requester's addr, data, strb and prot into the AW/W output registers.
  - Set awvalid=1 and wvalid=1, store the winner index, go to SEND.
  - awvalid rises on the edge after req is first sampled high: 1-cycle latency.
- SEND:
  - awvalid clears on the edge where awvalid&&awready; wvalid clears on the edge where wvalid&&wready. The two are independent; either order or simultaneous is legal.
  - The valid-and-not-ready case must hold valid and payload stable, per the AXI rule.
  - When both handshakes are complete (including the same-edge case), set bready=1 and go to RESP.
- RESP:
  - On bvalid&&bready: latch bresp into resp, set done[winner]=1, bready=0, ptr=(winner+1) mod NUM_REQ, go to DONE.
  - bvalid arriving before AW/W completes is ignored until RESP, because bready is low.
- DONE:
  - done and resp are valid for exactly this cycle; no arbitration occurs.
  - Next edge: done=0, go to IDLE.
  - A requester must drop req on the edge that ends DONE, or it is re-arbitrated as a new write.
- req/payload changes after grant are ignored; the latched copy is used. A req deasserted mid-transaction does not cancel it, and done still pulses.
- Throughput: best case 4 cycles per write (IDLE, SEND, RESP, DONE) with awready=wready=bvalid=1.
- Fairness: with all requesters continuously active, grants rotate 0,1,...,NUM_REQ-1,0 and no requester waits more than NUM_REQ-1 transactions.
- resp passes SLVERR/DECERR through unchanged; the arbiter does not retry.

Test Plan:
- Single write: req=0001, addr0=0x10, data0=0xDEADBEEF, strb0=0xF, prot0=0; slave always ready, bresp=OKAY -> awvalid at cycle 1 with awaddr=0x10, wdata=0xDEADBEEF; done=0001, resp=0 at cycle 3; busy=0 at cycle 4.
- Split handshakes: awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle; awvalid and awaddr stay stable 3 cycles; bready rises only after the AW handshake; done pulses once.
- Round-robin: req=1111 held, each requester dropping req only in its own DONE cycle and re-raising it 1 cycle later -> grant sequence 0,1,2,3,0,1; awaddr matches each requester's slice.
- Priority pointer: after requester 2 completes, req=0101 -> requester 0 granted; with req=1101 instead -> requester 3 granted.
- Error response: bresp=2'b10 -> resp=2'b10 with done[winner]; the next queued request proceeds normally.
- Reset mid-SEND: aresetn low while awvalid=1, wvalid=1 -> all valids and done drop asynchronously; after release, ptr=0 and a pending req=1000 is granted normally.

Source files
------------

// File: rtl/axi_lite_write_arbiter.sv
// rtl/axi_lite_write_arbiter.sv - round-robin arbiter sharing one AXI-Lite write master
// Single-beat writes from NUM_REQ clients are serialised onto AW/W/B and the bresp is returned to the winner.
module axi_lite_write_arbiter #(
   parameter int NUM_REQ          = 4,
   parameter int AXI_AWADDR_WIDTH = 8,
   parameter int AXI_WDATA_WIDTH  = 32
) (
   input  logic                                    aclk,
   input  logic                                    aresetn,
   input  logic [NUM_REQ-1:0]                      req,
   input  logic [NUM_REQ*AXI_AWADDR_WIDTH-1:0]     req_addr,
   input  logic [NUM_REQ*AXI_WDATA_WIDTH-1:0]      req_data,
   input  logic [NUM_REQ*AXI_WDATA_WIDTH/8-1:0]    req_strb,
   input  logic [NUM_REQ*3-1:0]                    req_prot,
   output logic [NUM_REQ-1:0]                      done,
   output logic [1:0]                              resp,
   output logic                                    busy,
   output logic                                    awvalid,
   input  logic                                    awready,
   output logic [AXI_AWADDR_WIDTH-1:0]             awaddr,
   output logic [2:0]                              awprot,
   output logic                                    wvalid,
   input  logic                                    wready,
   output logic [AXI_WDATA_WIDTH-1:0]              wdata,
   output logic [AXI_WDATA_WIDTH/8-1:0]            wstrb,
   input  logic                                    bvalid,
   output logic                                    bready,
   input  logic [1:0]                              bresp
);

   localparam int STRB_W = AXI_WDATA_WIDTH / 8;
   localparam int IDX_W  = $clog2(NUM_REQ);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEND = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

   logic [1:0]       state;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] winner;
   logic [IDX_W-1:0] grant;
   logic [IDX_W:0]   scan;
   logic             found;
   logic             aw_fin;
   logic             w_fin;

   // Scan from ptr upward with wrap; the first pending requester wins.
   always_comb begin
      grant = '0;
      found = 1'b0;
      scan  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan = {1'b0, ptr} + (IDX_W + 1)'(k);
         if (scan >= NUM_REQ_W) begin
            scan = scan - NUM_REQ_W;
         end
         if (!found && req[scan[IDX_W-1:0]]) begin
            grant = scan[IDX_W-1:0];
            found = 1'b1;
         end
      end
   end

   // A channel counts as finished if it already handshook or handshakes on this edge.
   assign aw_fin = !awvalid || awready;
   assign w_fin  = !wvalid || wready;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state   <= ST_IDLE;
         ptr     <= '0;
         winner  <= '0;
         done    <= '0;
         resp    <= 2'b00;
         busy    <= 1'b0;
         awvalid <= 1'b0;
         awaddr  <= '0;
         awprot  <= 3'b000;
         wvalid  <= 1'b0;
         wdata   <= '0;
         wstrb   <= '0;
         bready  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (found) begin
                  awaddr  <= req_addr[grant*AXI_AWADDR_WIDTH +: AXI_AWADDR_WIDTH];
                  awprot  <= req_prot[grant*3 +: 3];
                  wdata   <= req_data[grant*AXI_WDATA_WIDTH +: AXI_WDATA_WIDTH];
                  wstrb   <= req_strb[grant*STRB_W +: STRB_W];
                  awvalid <= 1'b1;
                  wvalid  <= 1'b1;
                  winner  <= grant;
                  busy    <= 1'b1;
                  state   <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (awvalid && awready) begin
                  awvalid <= 1'b0;
               end
               if (wvalid && wready) begin
                  wvalid <= 1'b0;
               end
               if (aw_fin && w_fin) begin
                  bready <= 1'b1;
                  state  <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (bvalid) begin
                  resp   <= bresp;
                  done   <= NUM_REQ'(1) << winner;
                  bready <= 1'b0;
                  ptr    <= (winner == LAST_IDX) ? '0 : winner + 1'b1;
                  state  <= ST_DONE;
               end
            end
            default: begin
               done  <= '0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_lite_write_arbiter.sv
// tb/tb_axi_lite_write_arbiter.sv - self-checking bench for axi_lite_write_arbiter
// A reactive slave model drives AW/W/B; a round-robin model predicts each winner.
module tb_axi_lite_write_arbiter;

   localparam int NR = 4;
   localparam int AW = 8;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic              aclk = 1'b0;
   logic              aresetn = 1'b0;
   logic [NR-1:0]     req = '0;
   logic [NR*AW-1:0]  req_addr;
   logic [NR*DW-1:0]  req_data;
   logic [NR*SW-1:0]  req_strb;
   logic [NR*3-1:0]   req_prot;
   logic [NR-1:0]     done;
   logic [1:0]        resp;
   logic              busy;
   logic              awvalid;
   logic              awready = 1'b0;
   logic [AW-1:0]     awaddr;
   logic [2:0]        awprot;
   logic              wvalid;
   logic              wready = 1'b0;
   logic [DW-1:0]     wdata;
   logic [SW-1:0]     wstrb;
   logic              bvalid = 1'b0;
   logic              bready;
   logic [1:0]        bresp = 2'b00;

   logic [AW-1:0] addr_a [NR];
   logic [DW-1:0] data_a [NR];
   logic [SW-1:0] strb_a [NR];
   logic [2:0]    prot_a [NR];

   int checks = 0;
   int errors = 0;
   int ptr_m  = 0;

   int            t_win, t_aw_first, t_aw_len, t_w_len, t_done_cyc;
   bit            t_ok;
   logic [AW-1:0] t_addr;
   logic [DW-1:0] t_data;
   logic [SW-1:0] t_strb;
   logic [2:0]    t_prot;
   logic [1:0]    t_resp;

   for (genvar g = 0; g < NR; g++) begin : g_pack
      assign req_addr[g*AW +: AW] = addr_a[g];
      assign req_data[g*DW +: DW] = data_a[g];
      assign req_strb[g*SW +: SW] = strb_a[g];
      assign req_prot[g*3 +: 3]   = prot_a[g];
   end

   axi_lite_write_arbiter #(
      .NUM_REQ(NR), .AXI_AWADDR_WIDTH(AW), .AXI_WDATA_WIDTH(DW)
   ) dut (
      .aclk(aclk), .aresetn(aresetn), .req(req),
      .req_addr(req_addr), .req_data(req_data), .req_strb(req_strb), .req_prot(req_prot),
      .done(done), .resp(resp), .busy(busy),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp)
   );

   always #5 aclk = ~aclk;

   function automatic int rr_pick(input logic [NR-1:0] r, input int p);
      for (int k = 0; k < NR; k++) begin
         if (r[(p + k) % NR]) return (p + k) % NR;
      end
      return -1;
   endfunction

   task automatic rand_payload();
      for (int i = 0; i < NR; i++) begin
         addr_a[i] = AW'($urandom);
         data_a[i] = $urandom;
         strb_a[i] = SW'($urandom);
         prot_a[i] = 3'($urandom);
      end
   endtask

   // Entered at a negedge with the DUT idle and req already applied; returns at the DONE negedge.
   task automatic do_txn(input int aw_dly, input int w_dly, input int b_dly,
                         input logic [1:0] br, input bit scramble);
      int aw_cnt = 0, w_cnt = 0, b_cnt = 0;
      bit aw_hs = 0, w_hs = 0, w_seen = 0;
      logic pav = 0, paw = 0, pwv = 0, pww = 0;
      logic [AW-1:0] pa = '0;
      logic [DW-1:0] pd = '0;
      logic [SW-1:0] ps = '0;
      t_win = -1; t_aw_first = -1; t_aw_len = 0; t_w_len = 0; t_done_cyc = -1; t_ok = 1;
      t_addr = '0; t_data = '0; t_strb = '0; t_prot = '0; t_resp = '0;
      for (int cyc = 1; cyc <= 200 && t_done_cyc < 0; cyc++) begin
         @(negedge aclk);
         if (pav && !paw && (awvalid !== 1'b1 || awaddr !== pa)) t_ok = 0;
         if (pwv && !pww && (wvalid !== 1'b1 || wdata !== pd || wstrb !== ps)) t_ok = 0;
         if (bready === 1'b1 && !(aw_hs && w_hs)) t_ok = 0;
         if (awvalid === 1'b1) begin
            t_aw_len++;
            if (t_aw_first < 0) begin
               t_aw_first = cyc; t_addr = awaddr; t_prot = awprot;
            end
         end
         if (wvalid === 1'b1) begin
            t_w_len++;
            if (!w_seen) begin
               w_seen = 1; t_data = wdata; t_strb = wstrb;
            end
         end
         if (done !== '0) begin
            t_done_cyc = cyc;
            t_resp = resp;
            for (int i = 0; i < NR; i++) begin
               if (done[i] === 1'b1) t_win = (t_win == -1) ? i : -2;
            end
            if (t_win >= 0) req[t_win] = 1'b0;
            awready = 0; wready = 0; bvalid = 0;
         end else begin
            if (scramble && cyc == 2) begin
               rand_payload();
               req = NR'($urandom);
            end
            pav = awvalid; pa = awaddr; pwv = wvalid; pd = wdata; ps = wstrb;
            if (awvalid === 1'b1) begin awready = (aw_cnt >= aw_dly); aw_cnt++; end
            else awready = 0;
            if (wvalid === 1'b1) begin wready = (w_cnt >= w_dly); w_cnt++; end
            else wready = 0;
            if (awvalid && awready) aw_hs = 1;
            if (wvalid && wready) w_hs = 1;
            paw = awready; pww = wready;
            if (bready === 1'b1) begin bvalid = (b_cnt >= b_dly); b_cnt++; end
            else bvalid = 0;
            bresp = br;
         end
      end
   endtask

   task automatic pulse_reset();
      aresetn = 0; req = '0; awready = 0; wready = 0; bvalid = 0;
      repeat (2) @(negedge aclk);
      aresetn = 1; ptr_m = 0;
      @(negedge aclk);
   endtask

   task automatic test_reset();
      aresetn = 0;
      #12;
      checks++; if ({awvalid, wvalid, bready, busy} !== 4'b0) begin
         errors++; $display("FAIL reset_ctrl got %b exp 0000", {awvalid, wvalid, bready, busy}); end
      checks++; if (done !== '0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
      checks++; if (resp !== 2'b00) begin errors++; $display("FAIL reset_resp got %b exp 00", resp); end
      checks++; if ({awaddr, awprot, wdata, wstrb} !== '0) begin
         errors++; $display("FAIL reset_payload got %h exp 0", {awaddr, awprot, wdata, wstrb}); end
      @(negedge aclk);
      aresetn = 1; ptr_m = 0;
      @(negedge aclk);
   endtask

   task automatic test_single_write();
      addr_a[0] = 8'h10; data_a[0] = 32'hDEADBEEF; strb_a[0] = 4'hF; prot_a[0] = 3'd0;
      req = 4'b0001;
      do_txn(0, 0, 0, 2'b00, 0);
      checks++; if (t_aw_first != 1) begin errors++; $display("FAIL single_aw_lat got %0d exp 1", t_aw_first); end
      checks++; if (t_addr !== 8'h10) begin errors++; $display("FAIL single_addr got %h exp 10", t_addr); end
      checks++; if (t_data !== 32'hDEADBEEF || t_strb !== 4'hF) begin
         errors++; $display("FAIL single_data got %h/%h exp deadbeef/f", t_data, t_strb); end
      checks++; if (t_done_cyc != 3 || t_win != 0) begin
         errors++; $display("FAIL single_done got cyc %0d win %0d exp cyc 3 win 0", t_done_cyc, t_win); end
      checks++; if (t_resp !== 2'b00) begin errors++; $display("FAIL single_resp got %b exp 00", t_resp); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_done got %b exp 1", busy); end
      ptr_m = 1;
      @(negedge aclk);
      checks++; if (busy !== 1'b0 || done !== '0) begin
         errors++; $display("FAIL single_idle got busy %b done %b exp 0/0", busy, done); end
   endtask

   task automatic test_split();
      rand_payload();
      req = 4'b0010;
      do_txn(3, 0, 0, 2'b00, 0);
      checks++; if (t_aw_len != 4 || t_w_len != 1) begin
         errors++; $display("FAIL split_aw_late got aw %0d w %0d exp 4/1", t_aw_len, t_w_len); end
      checks++; if (!t_ok || t_done_cyc != 6) begin
         errors++; $display("FAIL split_aw_proto got ok %0d cyc %0d exp 1/6", t_ok, t_done_cyc); end
      checks++; if (t_win != 1 || t_addr !== addr_a[1]) begin
         errors++; $display("FAIL split_aw_win got %0d/%h exp 1/%h", t_win, t_addr, addr_a[1]); end
      ptr_m = 2;
      @(negedge aclk);
      checks++; if (done !== '0) begin errors++; $display("FAIL split_single_pulse got %b exp 0", done); end
      req = 4'b0100;
      do_txn(0, 2, 1, 2'b00, 0);
      checks++; if (t_aw_len != 1 || t_w_len != 3 || !t_ok || t_win != 2) begin
         errors++; $display("FAIL split_w_late got aw %0d w %0d ok %0d win %0d exp 1/3/1/2",
                            t_aw_len, t_w_len, t_ok, t_win); end
      ptr_m = 3;
      @(negedge aclk);
   endtask

   task automatic test_round_robin();
      int exp;
      pulse_reset();
      rand_payload();
      req = 4'b1111;
      for (int n = 0; n < 6; n++) begin
         exp = rr_pick(req, ptr_m);
         do_txn($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), 2'b00, 0);
         checks++; if (t_win != n % NR || t_win != exp || t_addr !== addr_a[n % NR] || !t_ok) begin
            errors++; $display("FAIL rr_grant_%0d got %0d/%h exp %0d/%h", n, t_win, t_addr, n % NR, addr_a[n % NR]); end
         ptr_m = (exp + 1) % NR;
         @(negedge aclk);
         if (t_win >= 0) req[t_win] = 1'b1;
      end
      req = '0;
      do_txn(0, 0, 0, 2'b00, 0);
      ptr_m = (rr_pick(4'b1111, ptr_m) + 1) % NR;
      @(negedge aclk);
   endtask

   task automatic test_priority();
      req = 4'b0100;
      do_txn(0, 0, 0, 2'b00, 0);
      ptr_m = 3;
      @(negedge aclk);
      req = 4'b0101;
      do_txn(0, 0, 0, 2'b00, 0);
      checks++; if (t_win != 0) begin errors++; $display("FAIL prio_0101 got %0d exp 0", t_win); end
      @(negedge aclk);
      do_txn(0, 0, 0, 2'b00, 0);
      checks++; if (t_win != 2) begin errors++; $display("FAIL prio_left got %0d exp 2", t_win); end
      @(negedge aclk);
      req = 4'b1101;
      do_txn(0, 0, 0, 2'b00, 0);
      checks++; if (t_win != 3) begin errors++; $display("FAIL prio_1101 got %0d exp 3", t_win); end
      ptr_m = 0;
      @(negedge aclk);
      req = '0;
   endtask

   task automatic test_error_resp();
      int exp;
      req = 4'b0011;
      exp = rr_pick(req, ptr_m);
      do_txn(1, 0, 2, 2'b10, 0);
      checks++; if (t_resp !== 2'b10 || t_win != exp) begin
         errors++; $display("FAIL err_slverr got %b/%0d exp 10/%0d", t_resp, t_win, exp); end
      ptr_m = (exp + 1) % NR;
      @(negedge aclk);
      exp = rr_pick(req, ptr_m);
      do_txn(0, 0, 0, 2'b00, 0);
      checks++; if (t_resp !== 2'b00 || t_win != exp || exp < 0) begin
         errors++; $display("FAIL err_next got %b/%0d exp 00/%0d", t_resp, t_win, exp); end
      ptr_m = (exp + 1) % NR;
      @(negedge aclk);
   endtask

   task automatic test_reset_mid();
      req = 4'b0010;
      do_txn(0, 0, 0, 2'b00, 0);
      @(negedge aclk);
      req = 4'b0100;
      repeat (2) @(negedge aclk);
      checks++; if (awvalid !== 1'b1 || wvalid !== 1'b1) begin
         errors++; $display("FAIL rst_mid_send got %b%b exp 11", awvalid, wvalid); end
      #2 aresetn = 0;
      #1;
      checks++; if ({awvalid, wvalid, bready, busy, done} !== '0) begin
         errors++; $display("FAIL rst_mid_async got %b exp 0", {awvalid, wvalid, bready, busy, done}); end
      @(negedge aclk);
      aresetn = 1; ptr_m = 0;
      req = 4'b1001;
      do_txn(0, 0, 0, 2'b00, 0);
      checks++; if (t_win != 0) begin errors++; $display("FAIL rst_mid_ptr got %0d exp 0", t_win); end
      @(negedge aclk);
      do_txn(0, 0, 0, 2'b01, 0);
      checks++; if (t_win != 3 || t_resp !== 2'b01) begin
         errors++; $display("FAIL rst_mid_pending got %0d/%b exp 3/01", t_win, t_resp); end
      ptr_m = 0;
      @(negedge aclk);
      req = '0;
   endtask

   task automatic test_random();
      int exp;
      logic [1:0] br;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      logic [SW-1:0] es;
      logic [2:0] ep;
      for (int n = 0; n < 25; n++) begin
         rand_payload();
         req = req | NR'($urandom_range(1, (1 << NR) - 1));
         exp = rr_pick(req, ptr_m);
         ea = addr_a[exp]; ed = data_a[exp]; es = strb_a[exp]; ep = prot_a[exp];
         br = 2'($urandom);
         do_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), br, 1'($urandom));
         checks++; if (t_win != exp || t_resp !== br || t_done_cyc < 0) begin
            errors++; $display("FAIL rand_%0d_grant got %0d/%b exp %0d/%b", n, t_win, t_resp, exp, br); end
         checks++; if (t_addr !== ea || t_data !== ed || t_strb !== es || t_prot !== ep || !t_ok) begin
            errors++; $display("FAIL rand_%0d_payload got %h/%h/%h/%h ok %0d exp %h/%h/%h/%h",
                               n, t_addr, t_data, t_strb, t_prot, t_ok, ea, ed, es, ep); end
         ptr_m = (exp + 1) % NR;
         @(negedge aclk);
         checks++; if (done !== '0 || busy !== 1'b0) begin
            errors++; $display("FAIL rand_%0d_idle got done %b busy %b exp 0/0", n, done, busy); end
      end
   endtask

   initial begin
      rand_payload();
      test_reset();
      test_single_write();
      test_split();
      test_round_robin();
      test_priority();
      test_error_resp();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
